// File: rtl/fc_neuron_seq.sv
// Time-multiplexed fully-connected neuron: accumulates LANES signed products per beat
// and emits one optionally ReLU-clipped result per IN-element vector.
module fc_neuron_seq #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned IN      = 128,
  parameter int unsigned LANES   = 4,
  parameter int unsigned RELU_EN = 1,
  localparam int unsigned ACC_W  = 2 * WIDTH + $clog2(IN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  input  logic [LANES*WIDTH-1:0]   x,
  input  logic [LANES*WIDTH-1:0]   w,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         z,
  output logic                     err
);

  localparam int unsigned BEATS = IN / LANES;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PROD_W = 2 * WIDTH;

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        beat_cnt;

  logic                    accept_c;
  logic                    last_beat_c;
  logic signed [ACC_W-1:0] psum_c;
  logic signed [ACC_W-1:0] sum_c;
  logic signed [ACC_W-1:0] result_c;

  // Sum of this beat's lane products, each sign-extended to the accumulator width.
  function automatic logic signed [ACC_W-1:0] lane_sum(
    input logic [LANES*WIDTH-1:0] xv,
    input logic [LANES*WIDTH-1:0] wv
  );
    logic signed [ACC_W-1:0]  s;
    logic signed [WIDTH-1:0]  xa;
    logic signed [WIDTH-1:0]  wa;
    logic signed [PROD_W-1:0] p;
    s = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      xa = xv[k*WIDTH +: WIDTH];
      wa = wv[k*WIDTH +: WIDTH];
      p  = xa * wa;
      s  = s + ACC_W'(p);
    end
    return s;
  endfunction

  always_comb begin
    accept_c    = in_valid && (state == ST_ACC);
    last_beat_c = (beat_cnt == CNT_W'(BEATS - 1));
    psum_c      = lane_sum(x, w);
    sum_c       = acc + psum_c;
    result_c    = ((RELU_EN != 0) && (sum_c < 0)) ? '0 : sum_c;
  end

  // Next-state logic: the beat counter, not in_last, ends a vector.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACC: if (accept_c && last_beat_c) state_nxt = ST_OUT;
      ST_OUT: if (out_ready) state_nxt = ST_ACC;
      default: state_nxt = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_ACC;
      acc       <= '0;
      beat_cnt  <= '0;
      z         <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == ST_ACC);
      out_valid <= (state_nxt == ST_OUT);
      if (accept_c) begin
        if (last_beat_c) begin
          acc      <= '0;
          beat_cnt <= '0;
          z        <= result_c;
        end else begin
          acc      <= sum_c;
          beat_cnt <= beat_cnt + CNT_W'(1);
        end
        if (in_last != last_beat_c) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fc_neuron_seq.sv
// Self-checking bench: two neurons (ReLU on / off) share one input stream and are
// compared against a plain-arithmetic dot-product model.
module tb_fc_neuron_seq;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned IN    = 128;
  localparam int unsigned LANES = 4;
  localparam int unsigned BEATS = IN / LANES;
  localparam int unsigned ACC_W = 2 * WIDTH + $clog2(IN);

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_last;
  logic [LANES*WIDTH-1:0] x;
  logic [LANES*WIDTH-1:0] w;
  logic                   out_ready;
  logic                   in_ready_r, in_ready_p;
  logic                   out_valid_r, out_valid_p;
  logic [ACC_W-1:0]       z_r, z_p;
  logic                   err_r, err_p;

  int total = 0;
  int bad   = 0;
  int xs [IN];
  int ws [IN];
  logic exp_err = 1'b0;

  always #5 clk = ~clk;

  fc_neuron_seq #(.WIDTH(WIDTH), .IN(IN), .LANES(LANES), .RELU_EN(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r),
    .in_last(in_last), .x(x), .w(w), .out_valid(out_valid_r),
    .out_ready(out_ready), .z(z_r), .err(err_r)
  );

  fc_neuron_seq #(.WIDTH(WIDTH), .IN(IN), .LANES(LANES), .RELU_EN(0)) dut_p (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_p),
    .in_last(in_last), .x(x), .w(w), .out_valid(out_valid_p),
    .out_ready(out_ready), .z(z_p), .err(err_p)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint model_dot();
    longint s = 0;
    for (int i = 0; i < int'(IN); i++) s += longint'(xs[i]) * longint'(ws[i]);
    return s;
  endfunction

  function automatic logic [63:0] fit(input longint v);
    logic [63:0] m;
    m = (64'd1 << ACC_W) - 64'd1;
    return 64'(v) & m;
  endfunction

  task automatic fill_const(input int xv, input int wv);
    for (int i = 0; i < int'(IN); i++) begin
      xs[i] = xv;
      ws[i] = wv;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < int'(IN); i++) begin
      xs[i] = int'($urandom_range(0, 255)) - 128;
      ws[i] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  task automatic drive_beat(input int b, input logic last);
    for (int k = 0; k < int'(LANES); k++) begin
      x[k*WIDTH +: WIDTH] = WIDTH'(xs[b*int'(LANES) + k]);
      w[k*WIDTH +: WIDTH] = WIDTH'(ws[b*int'(LANES) + k]);
    end
    in_last  = last;
    in_valid = 1'b1;
    chk("in_ready_beat", 64'(in_ready_r & in_ready_p), 64'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    x        = $urandom;
    w        = $urandom;
  endtask

  // Streams the current vector, then checks the emitted result and backpressure hold.
  task automatic send_vector(input int gap_max, input int bad_beat, input int bp);
    longint s;
    logic [63:0] er, ep;
    for (int b = 0; b < int'(BEATS); b++) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin
        chk("out_valid_gap", 64'(out_valid_r | out_valid_p), 64'd0);
        tick();
      end
      drive_beat(b, (b == int'(BEATS) - 1) || (b == bad_beat));
      if (b == bad_beat) begin
        exp_err = 1'b1;
        chk("err_set", 64'(err_r & err_p), 64'd1);
      end
      if (b != int'(BEATS) - 1)
        chk("out_valid_mid", 64'(out_valid_r | out_valid_p), 64'd0);
    end
    s  = model_dot();
    er = fit((s < 0) ? 0 : s);
    ep = fit(s);
    chk("out_valid_r", 64'(out_valid_r), 64'd1);
    chk("out_valid_p", 64'(out_valid_p), 64'd1);
    chk("z_relu", 64'(z_r), er);
    chk("z_pass", 64'(z_p), ep);
    chk("in_ready_out", 64'(in_ready_r | in_ready_p), 64'd0);
    chk("err_r", 64'(err_r), 64'(exp_err));
    chk("err_p", 64'(err_p), 64'(exp_err));
    repeat (bp) begin
      tick();
      chk("bp_z_relu", 64'(z_r), er);
      chk("bp_z_pass", 64'(z_p), ep);
      chk("bp_out_valid", 64'(out_valid_r & out_valid_p), 64'd1);
      chk("bp_in_ready", 64'(in_ready_r | in_ready_p), 64'd0);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("rel_out_valid", 64'(out_valid_r | out_valid_p), 64'd0);
    chk("rel_in_ready", 64'(in_ready_r & in_ready_p), 64'd1);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) begin
      tick();
      chk("rst_out_valid", 64'(out_valid_r | out_valid_p), 64'd0);
      chk("rst_in_ready", 64'(in_ready_r & in_ready_p), 64'd1);
      chk("rst_z", 64'(z_r | z_p), 64'd0);
      chk("rst_err", 64'(err_r | err_p), 64'd0);
    end
    exp_err = 1'b0;
    rst_n   = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    x         = '0;
    w         = '0;
    out_ready = 1'b0;
    do_reset(2);

    // Basic positive sum: 128 * 1 * 2.
    fill_const(1, 2);
    send_vector(0, -1, 0);
    chk("z_basic_const", 64'(z_r), 64'd256);
    release_out();

    // Negative sum clipped by ReLU, passed through (wrapped to ACC_W) otherwise.
    fill_const(1, -2);
    send_vector(0, -1, 1);
    chk("z_neg_pass_const", 64'(z_p), 64'h7FFF00);
    release_out();

    // Extreme magnitude: no wrap.
    fill_const(-128, -128);
    send_vector(0, -1, 0);
    chk("z_extreme_const", 64'(z_r), 64'h200000);
    release_out();

    // Random vectors with input gaps and 5-cycle output backpressure.
    for (int v = 0; v < 4; v++) begin
      fill_rand();
      send_vector(2, -1, 5);
      release_out();
    end

    // Early in_last: err sets at once, vector still completes on the beat count.
    fill_rand();
    send_vector(1, 0, 2);
    release_out();
    fill_rand();
    send_vector(0, -1, 0);
    release_out();

    // Reset while a result is pending drops it.
    fill_rand();
    send_vector(0, -1, 1);
    do_reset(1);

    // Reset mid-vector discards the partial sum.
    fill_rand();
    drive_beat(0, 1'b0);
    do_reset(2);
    fill_const(3, 1);
    send_vector(0, -1, 0);
    chk("z_after_abort", 64'(z_r), 64'd384);
    release_out();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fc_neuron_seq.md
# fc_neuron_seq

Time-multiplexed, runtime-weighted successor to the fully-combinational constant-coefficient fully-connected neuron. It accepts one input vector of IN signed activations and IN signed weights as a stream of LANES-wide beats. Each beat's products are accumulated in a signed register, and one result per vector is emitted through optional ReLU. It sits between the activation buffer and the next layer's input FIFO. Area scales with LANES instead of IN.

## Interface
- WIDTH, 8, activation and weight bit width (signed two's complement).
- IN, 128, inputs per vector; must be a multiple of LANES.
- LANES, 4, multiply lanes per beat; 1 ≤ LANES ≤ IN.
- RELU_EN, 1, 1 = output ReLU, 0 = pass signed sum.
- Derived: BEATS = IN/LANES; ACC_W = 2*WIDTH+$clog2(IN); z width = ACC_W.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  block can accept a beat.
- in_last  in  1  marks final beat of a vector.
- x  in  LANES*WIDTH  activations; lane k = x[k*WIDTH +: WIDTH] = element beat*LANES+k.
- w  in  LANES*WIDTH  weights, same lane mapping.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- z  out  ACC_W  result, held stable while out_valid && !out_ready.
- err  out  1  sticky framing error.

## Operation
- States: ACC (in_ready=1, out_valid=0) and OUT (in_ready=0, out_valid=1).
- Beat accept = in_valid && in_ready.
- Per accepted beat: psum = Σ over k of signed(x_k)*signed(w_k), computed at full precision and sign-extended to ACC_W. Then acc ← acc + psum, and beat_cnt ← beat_cnt+1.
- Final beat is beat_cnt == BEATS-1:
  - z ← f(acc+psum), where f(v) = (RELU_EN && v<0) ? 0 : v.
  - acc ← 0, beat_cnt ← 0, state → OUT.
- OUT: on out_ready, state → ACC. z retains its value until the next result.
- Framing check, on each accepted beat:
  - in_last must equal (beat_cnt == BEATS-1).
  - On mismatch, err ← 1 (sticky until reset). Counting continues on beat_cnt only; in_last never ends a vector.
- No overflow is possible: ACC_W holds IN products of magnitude ≤ 2^(2*WIDTH-2).
  - Accumulation and output are exact, with no saturation.
  - Worst case, all inputs and weights at -2^(WIDTH-1), gives +IN*2^(2*WIDTH-2).
- LANES == IN: every accepted beat is final.

## Timing
- Reset (rst_n=0 at rising edge): state=ACC, acc=0, beat_cnt=0, z=0, out_valid=0, in_ready=1 in the following cycle, err=0.
- Reset mid-vector discards the partial sum. Reset during OUT drops the pending result.
- Latency: final beat accepted at edge t → out_valid=1 and z valid after edge t; visible during cycle t+1.
- Throughput: BEATS accept cycles + at least 1 OUT cycle per vector. The first beat of the next vector can be accepted in the cycle after out_ready is sampled high.
- in_valid gaps: acc and beat_cnt hold.
- x, w, in_last are sampled only on accept.
- Backpressure: out_valid stays 1 and z stays constant until out_ready=1. in_ready stays 0 throughout.
- in_ready and out_valid are registered state decodes. Neither depends combinationally on in_valid or out_ready.

## Test plan
- Basic sum: IN=8, LANES=4, RELU_EN=1; two beats of x=1, w=2 on all lanes, in_last on beat 2 → out_valid one cycle after beat 2, z=16, err=0.
- ReLU and sign:
  - x=1, w=-2 everywhere, RELU_EN=1 → z=0.
  - Same stimulus with RELU_EN=0 → z = -16 in ACC_W bits (0x7FFFF0 for ACC_W=23).
- Extreme width: IN=128, LANES=4, WIDTH=8, x=w=-128 on all 32 beats → z=2097152 (0x200000), no wrap.
- Backpressure and gaps: random in_valid gaps; out_ready held 0 for 5 cycles → z stable, in_ready=0 throughout, and the next vector is correct after release.
- Framing:
  - in_last on beat 1 of 2 → err=1 after that edge; result still emitted after beat 2.
  - err stays 1 until rst_n=0.
- Reset mid-vector: rst_n=0 after 1 of 2 beats, then a clean vector of x=3, w=1 → z=24. No residue from the aborted vector; all outputs at reset values during reset.
